// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source select, load funct3 codes, FSM states.
package wb_pkg;

  // Write-data source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // RISC-V load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    StIdle,
    StWaitMem
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select and sign/zero extension.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte and half; half ignores offset[0] (no misalignment check here)
  always_comb begin
    lane_b = word[7:0];
    unique case (offset)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];
  end

  // Extend according to load type; undefined codes pass the whole word
  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, lane_b};
      F3_LH:   result = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, lane_h};
      F3_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects register-file write data, waits for late load data,
// and issues a registered one-cycle write strobe.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_W    = 10,
  parameter int unsigned PC_STEP = 1,
  parameter int unsigned RA_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      wb_sel,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  input  logic [PC_W-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [RA_W-1:0] rd,
  input  logic            reg_write,
  output logic [XLEN-1:0] rd_wdata,
  output logic [RA_W-1:0] rd_addr,
  output logic            rd_we,
  output logic            busy
);

  wb_state_e       state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [RA_W-1:0] addr_q, addr_d;
  logic            we_q, we_d;

  logic [2:0]      ext_f3;
  logic [1:0]      ext_off;
  logic [XLEN-1:0] ext_data;
  logic [XLEN-1:0] pc_link;

  // In WAIT_MEM the extender must use the captured context, not the live inputs
  always_comb begin
    ext_f3  = (state_q == StWaitMem) ? f3_q  : funct3;
    ext_off = (state_q == StWaitMem) ? off_q : alu_result[1:0];
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .funct3(ext_f3),
    .offset(ext_off),
    .word  (mem_rdata),
    .result(ext_data)
  );

  assign pc_link  = XLEN'(pc) + XLEN'(PC_STEP);
  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q == StWaitMem);
  assign rd_wdata = wdata_q;
  assign rd_addr  = addr_q;
  assign rd_we    = we_q;

  // Next-state, captured load context and registered write-port values
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (wb_sel == WB_MEM && !mem_rvalid) begin
            f3_d    = funct3;
            off_d   = alu_result[1:0];
            rd_d    = rd;
            rw_d    = reg_write;
            state_d = StWaitMem;
          end else begin
            unique case (wb_sel)
              WB_ALU:  wdata_d = alu_result;
              WB_MEM:  wdata_d = ext_data;
              WB_PC:   wdata_d = pc_link;
              WB_IMM:  wdata_d = imm;
              default: wdata_d = alu_result;
            endcase
            addr_d = rd;
            we_d   = reg_write && (rd != '0);
          end
        end
      end
      StWaitMem: begin
        if (mem_rvalid) begin
          wdata_d = ext_data;
          addr_d  = rd_q;
          we_d    = rw_q && (rd_q != '0);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops any pending load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      f3_q    <= '0;
      off_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases plus randomized traffic
// compared against a transaction-level reference model.
module tb_writeback_stage;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_W    = 10;
  localparam int unsigned PC_STEP = 1;
  localparam int unsigned RA_W    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      wb_sel;
  logic [2:0]      funct3;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rvalid;
  logic [PC_W-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [RA_W-1:0] rd;
  logic            reg_write;
  logic [XLEN-1:0] rd_wdata;
  logic [RA_W-1:0] rd_addr;
  logic            rd_we;
  logic            busy;

  writeback_stage #(
    .XLEN   (XLEN),
    .PC_W   (PC_W),
    .PC_STEP(PC_STEP),
    .RA_W   (RA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wb_sel    (wb_sel),
    .funct3    (funct3),
    .alu_result(alu_result),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .pc        (pc),
    .imm       (imm),
    .rd        (rd),
    .reg_write (reg_write),
    .rd_wdata  (rd_wdata),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one optional pending load plus the last write-port values
  bit          m_pend;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [4:0]  m_rd;
  bit          m_rw;
  logic [31:0] m_wdata;
  logic [4:0]  m_addr;
  bit          m_we;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    int unsigned hsel;
    hsel = off / 2;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * hsel)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_f3    = '0;
    m_off   = '0;
    m_rd    = '0;
    m_rw    = 0;
    m_wdata = '0;
    m_addr  = '0;
    m_we    = 0;
  endtask

  task automatic drive(input bit v, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] mrd, input bit mrv,
                       input logic [9:0] p, input logic [31:0] im, input logic [4:0] r,
                       input bit rw);
    in_valid   = v;
    wb_sel     = sel;
    funct3     = f3;
    alu_result = alu;
    mem_rdata  = mrd;
    mem_rvalid = mrv;
    pc         = p;
    imm        = im;
    rd         = r;
    reg_write  = rw;
  endtask

  // Apply the current inputs for one clock and compare the write port afterwards
  task automatic step(input string tag);
    logic [31:0] res;
    check_eq({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, !m_pend});
    m_we = 0;
    if (!m_pend) begin
      if (in_valid) begin
        if (wb_sel == 2'd1 && !mem_rvalid) begin
          m_pend = 1;
          m_f3   = funct3;
          m_off  = alu_result[1:0];
          m_rd   = rd;
          m_rw   = reg_write;
        end else begin
          case (wb_sel)
            2'd0:    res = alu_result;
            2'd1:    res = ref_load(funct3, alu_result[1:0], mem_rdata);
            2'd2:    res = 32'(pc) + 32'(PC_STEP);
            default: res = imm;
          endcase
          m_wdata = res;
          m_addr  = rd;
          m_we    = reg_write && (rd != 0);
        end
      end
    end else if (mem_rvalid) begin
      m_pend  = 0;
      m_wdata = ref_load(m_f3, m_off, mem_rdata);
      m_addr  = m_rd;
      m_we    = m_rw && (m_rd != 0);
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".rd_we"}, {31'd0, rd_we}, {31'd0, m_we});
    check_eq({tag, ".rd_wdata"}, rd_wdata, m_wdata);
    check_eq({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, m_addr});
    check_eq({tag, ".busy"}, {31'd0, busy}, {31'd0, m_pend});
  endtask

  task automatic idle_inputs();
    drive(0, 2'd0, 3'd0, 32'd0, 32'd0, 0, 10'd0, 32'd0, 5'd0, 0);
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    check_eq("reset.rd_we", {31'd0, rd_we}, 32'd0);
    check_eq("reset.rd_wdata", rd_wdata, 32'd0);
    check_eq("reset.rd_addr", {27'd0, rd_addr}, 32'd0);
    check_eq("reset.busy", {31'd0, busy}, 32'd0);
    check_eq("reset.in_ready", {31'd0, in_ready}, 32'd1);
    #10;
    rst = 1'b0;

    // ALU path, then a quiet cycle to see the strobe drop
    drive(1, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 0, 10'd0, 32'd0, 5'd5, 1);
    step("alu");
    check_eq("alu.exact_we", {31'd0, rd_we}, 32'd1);
    check_eq("alu.exact_data", rd_wdata, 32'h1234_5678);
    idle_inputs();
    step("alu_idle");
    check_eq("alu.we_drop", {31'd0, rd_we}, 32'd0);

    // Load extension with data ready in the accepting cycle
    drive(1, 2'd1, 3'b000, 32'd3, 32'h80FF_7F01, 1, 10'd0, 32'd0, 5'd1, 1);
    step("lb_o3");
    check_eq("lb_o3.value", rd_wdata, 32'hFFFF_FF80);
    drive(1, 2'd1, 3'b100, 32'd3, 32'h80FF_7F01, 1, 10'd0, 32'd0, 5'd2, 1);
    step("lbu_o3");
    check_eq("lbu_o3.value", rd_wdata, 32'h0000_0080);
    drive(1, 2'd1, 3'b001, 32'd2, 32'h80FF_7F01, 1, 10'd0, 32'd0, 5'd3, 1);
    step("lh_o2");
    check_eq("lh_o2.value", rd_wdata, 32'hFFFF_80FF);
    drive(1, 2'd1, 3'b101, 32'd0, 32'h80FF_7F01, 1, 10'd0, 32'd0, 5'd4, 1);
    step("lhu_o0");
    check_eq("lhu_o0.value", rd_wdata, 32'h0000_7F01);
    drive(1, 2'd1, 3'b010, 32'd1, 32'h80FF_7F01, 1, 10'd0, 32'd0, 5'd6, 1);
    step("lw");
    check_eq("lw.value", rd_wdata, 32'h80FF_7F01);

    // Multi-cycle load; live inputs during the wait must not disturb the capture
    drive(1, 2'd1, 3'b010, 32'd0, 32'd0, 0, 10'd0, 32'd0, 5'd7, 1);
    step("mc_accept");
    check_eq("mc.busy", {31'd0, busy}, 32'd1);
    check_eq("mc.in_ready", {31'd0, in_ready}, 32'd0);
    drive(1, 2'd0, 3'b000, 32'h5555_5555, 32'd0, 0, 10'd0, 32'd0, 5'd9, 1);
    step("mc_wait1");
    step("mc_wait2");
    drive(1, 2'd0, 3'b000, 32'h5555_5555, 32'hAABB_CCDD, 1, 10'd0, 32'd0, 5'd9, 1);
    step("mc_done");
    check_eq("mc.value", rd_wdata, 32'hAABB_CCDD);
    check_eq("mc.addr", {27'd0, rd_addr}, 32'd7);
    check_eq("mc.idle", {31'd0, in_ready}, 32'd1);

    // Link and immediate
    drive(1, 2'd2, 3'd0, 32'd0, 32'd0, 0, 10'h3FF, 32'd0, 5'd8, 1);
    step("link");
    check_eq("link.value", rd_wdata, 32'h0000_0400);
    drive(1, 2'd3, 3'd0, 32'd0, 32'd0, 0, 10'd0, 32'hDEAD_0000, 5'd10, 1);
    step("imm");
    check_eq("imm.value", rd_wdata, 32'hDEAD_0000);

    // x0 suppression: data and address still update
    drive(1, 2'd0, 3'd0, 32'hCAFE_F00D, 32'd0, 0, 10'd0, 32'd0, 5'd0, 1);
    step("x0");
    check_eq("x0.we", {31'd0, rd_we}, 32'd0);

    // Reset mid-wait: immediate clear, later mem_rvalid produces nothing
    drive(1, 2'd1, 3'b010, 32'h0000_0011, 32'd0, 0, 10'd0, 32'd0, 5'd12, 1);
    step("rst_accept");
    idle_inputs();
    #3;
    rst = 1'b1;
    #1;
    check_eq("rst_mid.busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_mid.rd_wdata", rd_wdata, 32'd0);
    check_eq("rst_mid.rd_addr", {27'd0, rd_addr}, 32'd0);
    check_eq("rst_mid.rd_we", {31'd0, rd_we}, 32'd0);
    model_reset();
    #2;
    rst = 1'b0;
    drive(0, 2'd1, 3'b010, 32'd0, 32'h1111_2222, 1, 10'd0, 32'd0, 5'd12, 1);
    step("rst_late_rvalid");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] f3;
      logic [4:0] r;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
           (($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 2)) :
                                          3'($urandom_range(4, 5)));
      r  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      drive($urandom_range(0, 3) != 0, 2'($urandom), f3, $urandom, $urandom,
            $urandom_range(0, 2) == 0, 10'($urandom), $urandom, r, $urandom_range(0, 4) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Parametrised successor to the single-cycle writeback select mux. Chooses the register-file write data from four sources: ALU result, load data, PC+step and immediate.
- Performs RISC-V load byte/half extension and lane selection.
- Waits in a small FSM for multi-cycle memory read data.
- Drives a registered one-cycle write strobe to the register file.
- Sits between the data-memory interface and the register-file write port.

Parameters:
XLEN, 32, datapath width
PC_W, 10, program-counter width (word-addressed)
PC_STEP, 1, increment added to pc for link writes (1 = next word)
RA_W, 5, register address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  writeback request valid this cycle
in_ready  out  1  stage can accept a request (combinational from state)
wb_sel  in  2  0=ALU, 1=memory, 2=pc+PC_STEP, 3=immediate
funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
alu_result  in  XLEN  ALU output; bits [1:0] also give the load byte offset
mem_rdata  in  XLEN  raw word from data memory
mem_rvalid  in  1  mem_rdata valid this cycle
pc  in  PC_W  pc of the instruction
imm  in  XLEN  immediate (LUI path)
rd  in  RA_W  destination register
reg_write  in  1  instruction writes rd
rd_wdata  out  XLEN  registered write data
rd_addr  out  RA_W  registered destination
rd_we  out  1  registered one-cycle write strobe
busy  out  1  high while in WAIT_MEM

Behaviour:
- Reset (async, rst=1): state=IDLE; rd_wdata=0, rd_addr=0, rd_we=0, busy=0; captured context cleared. Applies immediately, including mid-WAIT_MEM. The pending load is dropped and no write is issued.
- States: IDLE, WAIT_MEM.
- in_ready = (state==IDLE).
- IDLE, handshake: in_valid=1 is accepted.
  - wb_sel!=1, or wb_sel==1 with mem_rvalid=1: compute the result and register it next edge. rd_we = reg_write && rd!=0. Latency is 1 cycle.
  - wb_sel==1 with mem_rvalid=0: capture funct3, alu_result[1:0], rd and reg_write; go to WAIT_MEM; rd_we=0.
- WAIT_MEM:
  - in_valid is ignored.
  - mem_rvalid=1: extend mem_rdata using the captured context, register it, pulse rd_we (same x0 rule), return to IDLE. Latency is 1 cycle after mem_rvalid.
  - No timeout.
- mem_rvalid while IDLE with no load accepted: ignored.
- rd_we is high for exactly one cycle per completed request, else 0. rd_wdata and rd_addr hold their last value when rd_we=0.
- rd==0 or reg_write=0: rd_we stays 0. rd_addr and rd_wdata still update.
- Load extension, offset o = alu_result[1:0]:
  - LB/LBU: byte mem_rdata[8o+7:8o], sign-/zero-extended.
  - LH/LHU: half selected by o[1], sign-/zero-extended. o[0] is ignored (misalignment is not detected here).
  - LW and undefined funct3: full word.
- PC path: zero-extend pc to XLEN, add PC_STEP, wrap modulo 2^XLEN. No truncation to PC_W.
- Immediate path: imm passed unchanged.

Decomposition:
- Shared package wb_pkg holds:
  - wb_sel encodings WB_ALU=0, WB_MEM=1, WB_PC=2, WB_IMM=3.
  - funct3 load codes.
  - FSM state encoding.
- One natural sub-module: load_extend. It is combinational, with inputs funct3, offset and word and output XLEN. It is unit-testable on its own.

Test Plan:
1. ALU path: in_valid=1, wb_sel=0, alu_result=0x12345678, rd=5, reg_write=1 -> next cycle rd_we=1 for one cycle, rd_wdata=0x12345678, rd_addr=5.
2. Load extension, mem_rdata=0x80FF7F01, mem_rvalid=1:
   - LB o=3 -> 0xFFFFFF80.
   - LBU o=3 -> 0x00000080.
   - LH o=2 -> 0xFFFF80FF.
   - LHU o=0 -> 0x00007F01.
   - LW -> 0x80FF7F01.
3. Multi-cycle load: wb_sel=1, mem_rvalid=0 -> busy=1, in_ready=0. A second in_valid in WAIT_MEM is ignored. mem_rvalid=1 three cycles later with 0xAABBCCDD, LW -> one rd_we with 0xAABBCCDD, back to IDLE.
4. Link and immediate:
   - pc=10'h3FF, wb_sel=2 -> rd_wdata=0x00000400.
   - wb_sel=3, imm=0xDEAD0000 -> 0xDEAD0000.
5. x0 suppression: rd=0, reg_write=1, wb_sel=0 -> rd_we stays 0.
6. Reset in WAIT_MEM: assert rst between edges -> immediate IDLE, all outputs 0. A later mem_rvalid produces no rd_we.
